iomem_router: RTL and testbench

//  - Sequences the PicoSoC iomem bus: decodes one 16 MB page, routes each access to one of NUM_SLAVES peripheral slots and returns a single-cycle iomem_ready.
//  - Sits between picosoc's iomem_* port and the board peripherals (GPIO, timers, etc.).
//  - Guards the CPU against hung or unmapped slots with a timeout and an error data word.

---
 rtl/iomem_router.sv | 156 +++++++++++++++
 tb/tb_iomem_router.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_router.sv
// iomem_router: claims one 16 MB page of the PicoSoC iomem bus and routes each access to one
// of NUM_SLAVES slots, with a per-access timeout. Optional error log: IOMEM_ROUTER_ERRLOG_EN.
module iomem_router #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [7:0]  BASE_PAGE  = 8'h03,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       iomem_valid,
  output logic                       iomem_ready,
  input  logic [3:0]                 iomem_wstrb,
  input  logic [31:0]                iomem_addr,
  input  logic [31:0]                iomem_wdata,
  output logic [31:0]                iomem_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata
`ifdef IOMEM_ROUTER_ERRLOG_EN
  ,
  output logic [7:0]                 err_count,
  output logic [31:0]                err_addr
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [NUM_SLAVES-1:0]   s_valid_reg, s_valid_next;
  logic                    ready_reg, ready_next;
  logic [31:0]             rdata_reg, rdata_next;
  logic [TW-1:0]           timer_reg, timer_next;

  logic [3:0]              slot;
  logic                    page_hit, slot_mapped, ready_hit, timed_out;
  logic [NUM_SLAVES-1:0]   slot_onehot;
  logic [31:0]             rdata_masked [NUM_SLAVES];
  logic [31:0]             rdata_sel;

  assign s_wstrb = iomem_wstrb;
  assign s_addr  = iomem_addr;
  assign s_wdata = iomem_wdata;

  assign slot        = iomem_addr[19:16];
  assign page_hit    = iomem_valid && (iomem_addr[31:24] == BASE_PAGE);
  assign slot_mapped = {1'b0, slot} < 5'(NUM_SLAVES);

  // The registered one-hot s_valid doubles as the latched slot select for ready and rdata.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
      assign slot_onehot[gi]  = (slot == 4'(gi));
      assign rdata_masked[gi] = s_valid_reg[gi] ? s_rdata[32*gi +: 32] : 32'h0;
    end
  endgenerate

  always_comb begin
    rdata_sel = 32'h0;
    for (int i = 0; i < NUM_SLAVES; i++) rdata_sel = rdata_sel | rdata_masked[i];
  end

  assign ready_hit = |(s_ready & s_valid_reg);
  assign timed_out = (timer_reg == TW'(TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    s_valid_next = s_valid_reg;
    ready_next   = 1'b0;
    rdata_next   = rdata_reg;
    timer_next   = timer_reg;
    case (state_reg)
      IDLE: begin
        if (page_hit) begin
          if (slot_mapped) begin
            s_valid_next = slot_onehot;
            timer_next   = '0;
            state_next   = ACTIVE;
          end else begin
            rdata_next = ERR_DATA;
            ready_next = 1'b1;
            state_next = DONE;
          end
        end
      end
      ACTIVE: begin
        // Slot ready takes priority over a timeout expiring in the same cycle.
        if (ready_hit) begin
          rdata_next   = rdata_sel;
          s_valid_next = '0;
          ready_next   = 1'b1;
          state_next   = DONE;
        end else if (timed_out) begin
          rdata_next   = ERR_DATA;
          s_valid_next = '0;
          ready_next   = 1'b1;
          state_next   = DONE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      s_valid_reg <= '0;
      ready_reg   <= 1'b0;
      rdata_reg   <= 32'h0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      s_valid_reg <= s_valid_next;
      ready_reg   <= ready_next;
      rdata_reg   <= rdata_next;
      timer_reg   <= timer_next;
    end
  end

  assign s_valid     = s_valid_reg;
  assign iomem_ready = ready_reg;
  assign iomem_rdata = rdata_reg;

`ifdef IOMEM_ROUTER_ERRLOG_EN
  logic        err_event;
  logic [7:0]  err_count_reg;
  logic [31:0] err_addr_reg;

  assign err_event = ((state_reg == IDLE) && page_hit && !slot_mapped) ||
                     ((state_reg == ACTIVE) && !ready_hit && timed_out);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count_reg <= 8'h0;
      err_addr_reg  <= 32'h0;
    end else if (err_event) begin
      if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      err_addr_reg <= iomem_addr;
    end
  end

  assign err_count = err_count_reg;
  assign err_addr  = err_addr_reg;
`else
  // Error responses still return ERR_DATA; only the log registers are absent.
`endif

endmodule

// File: tb/tb_iomem_router.sv
// Self-checking bench for iomem_router (NUM_SLAVES=4, TIMEOUT=8) with a transaction-level model.
module tb_iomem_router;
  localparam int          NS  = 4;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              iomem_valid = 1'b0;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb = 4'h0;
  logic [31:0]       iomem_addr = 32'h0;
  logic [31:0]       iomem_wdata = 32'h0;
  logic [31:0]       iomem_rdata;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready = '0;
  logic [3:0]        s_wstrb;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [32*NS-1:0]  s_rdata = '0;
`ifdef IOMEM_ROUTER_ERRLOG_EN
  logic [7:0]        err_count;
  logic [31:0]       err_addr;
`endif

  iomem_router #(.NUM_SLAVES(NS), .BASE_PAGE(8'h03), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
`ifdef IOMEM_ROUTER_ERRLOG_EN
    , .err_count(err_count), .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;
  int          exp_err_count = 0;
  logic [31:0] exp_err_addr = 32'h0;

  // Observed results of one transaction
  int          o_lat, o_vcyc, o_pulses;
  logic [31:0] o_rd, o_slot_data;
  bit          o_onehot_bad, o_pass_bad;
  // Expected results from the model
  int          e_lat, e_vcyc;
  logic [31:0] e_rd;
  bit          e_err;

  // Model: delay = cycles the slot keeps s_valid waiting before answering (0 = never answers).
  task automatic model(input logic [31:0] addr, input int delay, input logic [31:0] slot_data);
    int slot;
    slot = int'(addr[19:16]);
    if (addr[31:24] != 8'h03) begin
      e_lat = 0; e_vcyc = 0; e_rd = last_rdata; e_err = 0;
    end else if (slot >= NS) begin
      e_lat = 1; e_vcyc = 0; e_rd = ERR; e_err = 1;
    end else if (delay != 0 && delay <= TO) begin
      e_lat = delay + 1; e_vcyc = delay; e_rd = slot_data; e_err = 0;
    end else begin
      e_lat = TO + 1; e_vcyc = TO; e_rd = ERR; e_err = 1;
    end
    if (e_err) begin
      if (exp_err_count < 255) exp_err_count++;
      exp_err_addr = addr;
    end
    if (e_lat != 0) last_rdata = e_rd;
  endtask

  // Drives one CPU access and plays the addressed slot; other slots toggle s_ready randomly.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                         input int delay, input int budget, input bit fix, input logic [31:0] fixed);
    int slot, n;
    logic [NS-1:0] mask;
    slot = int'(addr[19:16]);
    mask = (slot < NS) ? (NS'(1) << slot) : '0;
    o_lat = 0; o_vcyc = 0; o_pulses = 0; o_onehot_bad = 0; o_pass_bad = 0; n = 0;
    @(posedge clk); #1;
    if (iomem_ready) o_pulses++;
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
    if (fix && slot < NS) s_rdata[32*slot +: 32] = fixed;
    o_slot_data = (slot < NS) ? s_rdata[32*slot +: 32] : 32'h0;
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb; iomem_wdata = wdata;
    s_ready = NS'($urandom) & ~mask;
    for (int c = 1; c <= budget && o_lat == 0; c++) begin
      @(posedge clk); #1;
      if (s_addr !== addr || s_wstrb !== wstrb || s_wdata !== wdata) o_pass_bad = 1;
      if (s_valid !== '0 && s_valid !== mask) o_onehot_bad = 1;
      if (mask != '0 && s_valid === mask) begin o_vcyc++; n++; end
      if (iomem_ready) begin
        o_pulses++; o_lat = c; o_rd = iomem_rdata;
      end
      s_ready = (NS'($urandom) & ~mask) | ((delay != 0 && n >= delay) ? mask : '0);
    end
    if (o_lat == 0) o_rd = iomem_rdata;
    iomem_valid = 1'b0;
    s_ready = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (s_valid !== '0)       begin errors++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", iomem_ready); end
    checks++; if (iomem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", iomem_rdata); end
`ifdef IOMEM_ROUTER_ERRLOG_EN
    checks++; if (err_count !== 8'h0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_errlog got=%0d/%h exp=0/0", err_count, err_addr); end
`endif
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_read_slot1();
    run_txn(32'h0301_0004, 4'h0, 32'h0, 2, TO + 6, 1, 32'h1234_5678);
    model(32'h0301_0004, 2, o_slot_data);
    $display("read 03010004 lat=%0d vcyc=%0d rdata=%h", o_lat, o_vcyc, o_rd);
    checks++; if (o_lat !== e_lat)       begin errors++; $display("FAIL rd1_latency got=%0d exp=%0d", o_lat, e_lat); end
    checks++; if (o_vcyc !== e_vcyc || o_onehot_bad) begin errors++; $display("FAIL rd1_s_valid cycles=%0d exp=%0d onehot_bad=%0d", o_vcyc, e_vcyc, o_onehot_bad); end
    checks++; if (o_rd !== 32'h1234_5678) begin errors++; $display("FAIL rd1_rdata got=%h exp=12345678", o_rd); end
    checks++; if (o_pulses !== 1)        begin errors++; $display("FAIL rd1_pulses got=%0d exp=1", o_pulses); end
  endtask

  task automatic test_write();
    run_txn(32'h0300_0000, 4'b0011, 32'hA5A5_00FF, 1, TO + 6, 0, 32'h0);
    model(32'h0300_0000, 1, o_slot_data);
    $display("write 03000000 lat=%0d vcyc=%0d", o_lat, o_vcyc);
    checks++; if (o_pass_bad)            begin errors++; $display("FAIL wr_passthrough got=bad exp=ok"); end
    checks++; if (o_lat !== e_lat || o_vcyc !== e_vcyc) begin errors++; $display("FAIL wr_latency got=%0d/%0d exp=%0d/%0d", o_lat, o_vcyc, e_lat, e_vcyc); end
    checks++; if (o_rd !== e_rd || o_pulses !== 1) begin errors++; $display("FAIL wr_rdata got=%h pulses=%0d exp=%h pulses=1", o_rd, o_pulses, e_rd); end
  endtask

  task automatic test_timeout();
    run_txn(32'h0302_0000, 4'h0, 32'h0, 0, TO + 6, 0, 32'h0);
    model(32'h0302_0000, 0, o_slot_data);
    $display("timeout 03020000 lat=%0d vcyc=%0d rdata=%h", o_lat, o_vcyc, o_rd);
    checks++; if (o_vcyc !== TO || o_lat !== TO + 1) begin errors++; $display("FAIL to_timing got=%0d/%0d exp=%0d/%0d", o_vcyc, o_lat, TO, TO + 1); end
    checks++; if (o_rd !== e_rd)         begin errors++; $display("FAIL to_rdata got=%h exp=%h", o_rd, e_rd); end
`ifdef IOMEM_ROUTER_ERRLOG_EN
    checks++; if (err_count !== 8'(exp_err_count) || err_addr !== 32'h0302_0000) begin errors++; $display("FAIL to_errlog got=%0d/%h exp=%0d/03020000", err_count, err_addr, exp_err_count); end
`endif
    // Ready arriving in the last allowed cycle beats the timeout.
    run_txn(32'h0303_0010, 4'h0, 32'h0, TO, TO + 6, 0, 32'h0);
    model(32'h0303_0010, TO, o_slot_data);
    $display("ready_at_timeout 03030010 lat=%0d rdata=%h", o_lat, o_rd);
    checks++; if (o_lat !== e_lat || o_rd !== e_rd) begin errors++; $display("FAIL edge_ready got=%0d/%h exp=%0d/%h", o_lat, o_rd, e_lat, e_rd); end
`ifdef IOMEM_ROUTER_ERRLOG_EN
    checks++; if (err_count !== 8'(exp_err_count)) begin errors++; $display("FAIL edge_errcount got=%0d exp=%0d", err_count, exp_err_count); end
`endif
  endtask

  task automatic test_unmapped();
    run_txn(32'h0307_0000, 4'h0, 32'h0, 1, TO + 6, 0, 32'h0);
    model(32'h0307_0000, 1, o_slot_data);
    $display("unmapped 03070000 lat=%0d rdata=%h", o_lat, o_rd);
    checks++; if (o_lat !== e_lat || o_vcyc !== 0 || o_onehot_bad) begin errors++; $display("FAIL unm_timing got=%0d vcyc=%0d exp=%0d vcyc=0", o_lat, o_vcyc, e_lat); end
    checks++; if (o_rd !== e_rd)         begin errors++; $display("FAIL unm_rdata got=%h exp=%h", o_rd, e_rd); end
`ifdef IOMEM_ROUTER_ERRLOG_EN
    checks++; if (err_count !== 8'(exp_err_count) || err_addr !== exp_err_addr) begin errors++; $display("FAIL unm_errlog got=%0d/%h exp=%0d/%h", err_count, err_addr, exp_err_count, exp_err_addr); end
`endif
    run_txn(32'h0200_0000, 4'h0, 32'h0, 1, 20, 0, 32'h0);
    model(32'h0200_0000, 1, o_slot_data);
    $display("other_page 02000000 pulses=%0d vcyc=%0d", o_pulses, o_vcyc);
    checks++; if (o_pulses !== 0 || o_vcyc !== 0 || o_onehot_bad) begin errors++; $display("FAIL page_ignore pulses=%0d vcyc=%0d exp=0/0", o_pulses, o_vcyc); end
    checks++; if (o_rd !== e_rd)         begin errors++; $display("FAIL rdata_hold got=%h exp=%h", o_rd, e_rd); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = {8'h03, 4'h0, 4'(3 - k), 16'h0040};
      run_txn(a, 4'hF, $urandom, 1, TO + 6, 0, 32'h0);
      model(a, 1, o_slot_data);
      $display("b2b addr=%h lat=%0d rdata=%h", a, o_lat, o_rd);
      checks++; if (o_lat !== e_lat || o_rd !== e_rd || o_pulses !== 1 || o_onehot_bad) begin errors++; $display("FAIL b2b_%0d got=%0d/%h/%0d exp=%0d/%h/1", k, o_lat, o_rd, o_pulses, e_lat, e_rd); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int d;
      a = {($urandom_range(0, 9) == 0) ? 8'h02 : 8'h03, 4'h0, 4'($urandom_range(0, 5)), 16'($urandom & 32'hFFFC)};
      d = $urandom_range(0, 10);
      run_txn(a, 4'($urandom), $urandom, d, (a[31:24] == 8'h03) ? TO + 6 : 6, 0, 32'h0);
      model(a, d, o_slot_data);
      $display("rand %0d addr=%h delay=%0d lat=%0d vcyc=%0d rdata=%h", k, a, d, o_lat, o_vcyc, o_rd);
      checks++;
      if (o_lat !== e_lat || o_vcyc !== e_vcyc || o_rd !== e_rd || o_onehot_bad || o_pass_bad ||
          o_pulses !== (e_lat != 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_%0d got lat=%0d vcyc=%0d rd=%h pulses=%0d oh=%0d pt=%0d exp lat=%0d vcyc=%0d rd=%h",
                 k, o_lat, o_vcyc, o_rd, o_pulses, o_onehot_bad, o_pass_bad, e_lat, e_vcyc, e_rd);
      end
`ifdef IOMEM_ROUTER_ERRLOG_EN
      checks++; if (err_count !== 8'(exp_err_count) || err_addr !== exp_err_addr) begin errors++; $display("FAIL rand_errlog_%0d got=%0d/%h exp=%0d/%h", k, err_count, err_addr, exp_err_count, exp_err_addr); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 32'h0303_0000; iomem_wstrb = 4'h0; s_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_valid !== 4'b1000) begin errors++; $display("FAIL mid_active got=%b exp=1000", s_valid); end
    #2 resetn = 1'b0;
    #1;
    $display("reset asserted mid-transaction s_valid=%b ready=%b rdata=%h", s_valid, iomem_ready, iomem_rdata);
    checks++; if (s_valid !== '0 || iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset got=%b/%b/%h exp=0/0/0", s_valid, iomem_ready, iomem_rdata); end
`ifdef IOMEM_ROUTER_ERRLOG_EN
    checks++; if (err_count !== 8'h0 || err_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_errlog got=%0d/%h exp=0/0", err_count, err_addr); end
`endif
    iomem_valid = 1'b0;
    last_rdata = 32'h0; exp_err_count = 0; exp_err_addr = 32'h0;
    @(posedge clk); #1 resetn = 1'b1;
    run_txn(32'h0300_0008, 4'h0, 32'h0, 1, TO + 6, 0, 32'h0);
    model(32'h0300_0008, 1, o_slot_data);
    $display("post_reset read 03000008 lat=%0d rdata=%h", o_lat, o_rd);
    checks++; if (o_lat !== e_lat || o_rd !== e_rd || o_pulses !== 1) begin errors++; $display("FAIL post_reset got=%0d/%h exp=%0d/%h", o_lat, o_rd, e_lat, e_rd); end
  endtask

  initial begin
    test_reset();
    test_read_slot1();
    test_write();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
